// File: rtl/connect_n_if.sv
// Button, display-read and status bundle between the user panel/scanner and connect_n_game.
// Defining CONNECT_UNDO_EN adds the undo button and the undo_avail status.
interface connect_n_if #(
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 3
);
    logic                move_right;
    logic                move_left;
    logic                drop_piece;
    logic                restart;
    logic [ROW_BITS-1:0] rd_row;
    logic [COL_BITS-1:0] rd_col;
    logic [1:0]          rd_data;
    logic [COL_BITS-1:0] cur_col;
    logic [1:0]          cur_player;
    logic [1:0]          winner;
    logic                draw;
    logic                busy;
`ifdef CONNECT_UNDO_EN
    logic                undo;
    logic                undo_avail;
`endif

    modport master (
`ifdef CONNECT_UNDO_EN
        output undo,
        input  undo_avail,
`endif
        output move_right, move_left, drop_piece, restart, rd_row, rd_col,
        input  rd_data, cur_col, cur_player, winner, draw, busy
    );

    modport slave (
`ifdef CONNECT_UNDO_EN
        input  undo,
        output undo_avail,
`endif
        input  move_right, move_left, drop_piece, restart, rd_row, rd_col,
        output rd_data, cur_col, cur_player, winner, draw, busy
    );
endinterface

// File: rtl/connect_n_game.sv
// Connect-N controller: board, column fill counters, button edges, turns, win/draw scan.
// CONNECT_UNDO_EN enables one-level undo. States: CLEAR sweep | IDLE wait input |
// WRITE place piece | CHECK scan 4 axes | WIN / DRAW terminal until restart.
module connect_n_game #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int COL_BITS    = 3,
    parameter int ROW_BITS    = 3,
    parameter int WIN_LEN     = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    connect_n_if.slave bus
);
`ifdef CONNECT_UNDO_EN
    localparam int NBTN = 5;
`else
    localparam int NBTN = 4;
`endif
    localparam int                  PC_W     = ROW_BITS + COL_BITS + 1;
    localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS + 1)'(ROWS);
    localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS + 1)'(COLS);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [PC_W-1:0]     TOTAL    = PC_W'(ROWS * COLS);
    localparam logic [5:0]          WIN_W    = 6'(WIN_LEN);
    localparam logic [4:0]          LIMIT    = 5'(WIN_LEN - 1);
    localparam logic [1:0]          P1       = 2'b01;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_CHECK, S_WIN, S_DRAW} state_t;
    state_t state_q, state_d;

    logic [NBTN-1:0] btn_raw, btn_prev, btn_edge;
    logic [NBTN-1:0] sync_q [SYNC_STAGES];
    logic            ev_right, ev_left, ev_drop, ev_restart, undo_fire;

    logic [1:0]          cells   [ROWS][COLS];
    logic [ROW_BITS:0]   col_cnt [COLS];
    logic [COL_BITS-1:0] cur_col_q, clr_col_q, mv_col_q;
    logic [ROW_BITS-1:0] mv_row_q;
    logic [1:0]          cur_player_q, winner_q, axis_q;
    logic                draw_q, side_q, undo_avail_q;
    logic [PC_W-1:0]     piece_cnt_q;
    logic [4:0]          step_q;
    logic [5:0]          run_q, run_next;
    logic                hit, in_board, side_done, run_win;
    int                  dr, dc, pr, pc;

`ifdef CONNECT_UNDO_EN
    assign btn_raw = {bus.undo, bus.restart, bus.drop_piece, bus.move_left, bus.move_right};
`else
    assign btn_raw = {bus.restart, bus.drop_piece, bus.move_left, bus.move_right};
`endif

    // Sync chain and edge flop reset high so a button held through reset stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            btn_prev <= '1;
        end else begin
            sync_q[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            btn_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign btn_edge   = sync_q[SYNC_STAGES-1] & ~btn_prev;
    assign ev_right   = btn_edge[0] & ~btn_edge[1];
    assign ev_left    = btn_edge[1] & ~btn_edge[0];
    assign ev_drop    = btn_edge[2];
    assign ev_restart = btn_edge[3];
`ifdef CONNECT_UNDO_EN
    assign undo_fire  = (state_q == S_IDLE) && btn_edge[4] && undo_avail_q && !ev_restart;
`else
    assign undo_fire  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        dr = 0;
        dc = 1;
        case (axis_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        if (side_q) begin
            dr = -dr;
            dc = -dc;
        end
        pr        = int'(mv_row_q) + dr * int'(step_q);
        pc        = int'(mv_col_q) + dc * int'(step_q);
        in_board  = (pr >= 0) && (pr < ROWS) && (pc >= 0) && (pc < COLS);
        hit       = in_board && (cells[pr[ROW_BITS-1:0]][pc[COL_BITS-1:0]] == cur_player_q);
        run_next  = run_q + 6'(hit);
        side_done = !hit || (step_q == LIMIT);
        run_win   = run_next >= WIN_W;

        case (state_q)
            S_CLEAR: if (clr_col_q == LAST_COL) state_d = S_IDLE;
            S_IDLE: begin
                if (ev_restart)
                    state_d = S_CLEAR;
                else if (ev_drop && !undo_fire && (col_cnt[cur_col_q] < ROWS_W))
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = S_CHECK;
            S_CHECK: begin
                if (side_done) begin
                    if (run_win)
                        state_d = S_WIN;
                    else if (side_q && (axis_q == 2'd3))
                        state_d = (piece_cnt_q == TOTAL) ? S_DRAW : S_IDLE;
                end
            end
            S_WIN, S_DRAW: if (ev_restart) state_d = S_CLEAR;
            default: state_d = S_CLEAR;
        endcase
    end

    // Board storage has no reset; the CLEAR sweep after reset zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            col_cnt[clr_col_q] <= '0;
            for (int r = 0; r < ROWS; r++) cells[r][clr_col_q] <= 2'b00;
        end else if (state_q == S_WRITE) begin
            cells[mv_row_q][mv_col_q] <= cur_player_q;
            col_cnt[mv_col_q]         <= col_cnt[mv_col_q] + (ROW_BITS + 1)'(1);
        end else if (undo_fire) begin
            cells[mv_row_q][mv_col_q] <= 2'b00;
            col_cnt[mv_col_q]         <= col_cnt[mv_col_q] - (ROW_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_col_q    <= '0;
            cur_player_q <= P1;
            winner_q     <= 2'b00;
            draw_q       <= 1'b0;
            piece_cnt_q  <= '0;
            clr_col_q    <= '0;
            mv_row_q     <= '0;
            mv_col_q     <= '0;
            axis_q       <= 2'd0;
            side_q       <= 1'b0;
            step_q       <= 5'd1;
            run_q        <= 6'd1;
            undo_avail_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_col_q    <= (clr_col_q == LAST_COL) ? '0 : clr_col_q + COL_BITS'(1);
                    piece_cnt_q  <= '0;
                    winner_q     <= 2'b00;
                    draw_q       <= 1'b0;
                    cur_player_q <= P1;
                    cur_col_q    <= '0;
                    undo_avail_q <= 1'b0;
                end
                S_IDLE: begin
                    if (ev_right)
                        cur_col_q <= (cur_col_q == LAST_COL) ? '0 : cur_col_q + COL_BITS'(1);
                    else if (ev_left)
                        cur_col_q <= (cur_col_q == '0) ? LAST_COL : cur_col_q - COL_BITS'(1);
                    if (state_d == S_WRITE) begin
                        mv_row_q <= col_cnt[cur_col_q][ROW_BITS-1:0];
                        mv_col_q <= cur_col_q;
                    end
                    if (undo_fire) begin
                        piece_cnt_q  <= piece_cnt_q - PC_W'(1);
                        cur_player_q <= cur_player_q ^ 2'b11;
                        undo_avail_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (piece_cnt_q != '1) piece_cnt_q <= piece_cnt_q + PC_W'(1);
                    axis_q       <= 2'd0;
                    side_q       <= 1'b0;
                    step_q       <= 5'd1;
                    run_q        <= 6'd1;
                    undo_avail_q <= 1'b1;
                end
                S_CHECK: begin
                    if (!side_done) begin
                        step_q <= step_q + 5'd1;
                        run_q  <= run_next;
                    end else if (run_win) begin
                        winner_q     <= cur_player_q;
                        undo_avail_q <= 1'b0;
                    end else if (!side_q) begin
                        side_q <= 1'b1;
                        step_q <= 5'd1;
                        run_q  <= run_next;
                    end else if (axis_q == 2'd3) begin
                        if (piece_cnt_q == TOTAL) begin
                            draw_q       <= 1'b1;
                            undo_avail_q <= 1'b0;
                        end else begin
                            cur_player_q <= cur_player_q ^ 2'b11;
                        end
                    end else begin
                        axis_q <= axis_q + 2'd1;
                        side_q <= 1'b0;
                        step_q <= 5'd1;
                        run_q  <= 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data    = (({1'b0, bus.rd_row} < ROWS_W) && ({1'b0, bus.rd_col} < COLS_W))
                            ? cells[bus.rd_row][bus.rd_col] : 2'b00;
    assign bus.cur_col    = cur_col_q;
    assign bus.cur_player = cur_player_q;
    assign bus.winner     = winner_q;
    assign bus.draw       = draw_q;
    assign bus.busy       = (state_q == S_CLEAR) || (state_q == S_WRITE) || (state_q == S_CHECK);
`ifdef CONNECT_UNDO_EN
    assign bus.undo_avail = undo_avail_q;
`endif
endmodule

// File: tb/tb_connect_n_game.sv
// Scoreboard bench for connect_n_game: an 8x8 connect-four instance and a 4x4 connect-three instance.
module tb_connect_n_game;
    localparam int BTN_R = 0, BTN_L = 1, BTN_DROP = 2, BTN_RST = 3, BTN_UNDO = 4;
    localparam int SEL_COL = 0, SEL_PLY = 1, SEL_WIN = 2, SEL_DRAW = 3, SEL_BUSY = 4,
                   SEL_CELL = 5, SEL_UNDO = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    connect_n_if #(.ROW_BITS(3), .COL_BITS(3)) b8();
    connect_n_if #(.ROW_BITS(2), .COL_BITS(2)) b4();

    connect_n_game #(.COLS(8), .ROWS(8), .COL_BITS(3), .ROW_BITS(3), .WIN_LEN(4), .SYNC_STAGES(2))
        dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    connect_n_game #(.COLS(4), .ROWS(4), .COL_BITS(2), .ROW_BITS(2), .WIN_LEN(3), .SYNC_STAGES(2))
        dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        string tag;
        int    d;
        int    sel;
        int    r;
        int    c;
        int    val;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int mcol[2];
    int mply[2];
    int mh[2][16];
    int mcell[2][16][16];

    task automatic check(input string tag, input int obs_v, input int exp_v);
        n_tests++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs_v, exp_v);
        end
    endtask

    function automatic int dim(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic int obs(input int d, input int sel);
        int v;
        v = 0;
        if (d == 0) begin
            case (sel)
                SEL_COL:  v = int'(b8.cur_col);
                SEL_PLY:  v = int'(b8.cur_player);
                SEL_WIN:  v = int'(b8.winner);
                SEL_DRAW: v = int'(b8.draw);
                SEL_BUSY: v = int'(b8.busy);
                SEL_CELL: v = int'(b8.rd_data);
`ifdef CONNECT_UNDO_EN
                SEL_UNDO: v = int'(b8.undo_avail);
`endif
                default:  v = -1;
            endcase
        end else begin
            case (sel)
                SEL_COL:  v = int'(b4.cur_col);
                SEL_PLY:  v = int'(b4.cur_player);
                SEL_WIN:  v = int'(b4.winner);
                SEL_DRAW: v = int'(b4.draw);
                SEL_BUSY: v = int'(b4.busy);
                SEL_CELL: v = int'(b4.rd_data);
`ifdef CONNECT_UNDO_EN
                SEL_UNDO: v = int'(b4.undo_avail);
`endif
                default:  v = -1;
            endcase
        end
        return v;
    endfunction

    task automatic push_exp(input string tag, input int d, input int sel, input int val,
                            input int r = 0, input int c = 0);
        exp_t e;
        e.tag = tag; e.d = d; e.sel = sel; e.r = r; e.c = c; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int   o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == SEL_CELL) begin
                if (e.d == 0) begin b8.rd_row = 3'(e.r); b8.rd_col = 3'(e.c); end
                else          begin b4.rd_row = 2'(e.r); b4.rd_col = 2'(e.c); end
            end
            #1;
            o = obs(e.d, e.sel);
            check(e.tag, o, e.val);
        end
    endtask

    task automatic set_btn(input int d, input int b, input logic v);
        if (d == 0) begin
            case (b)
                BTN_R:    b8.move_right = v;
                BTN_L:    b8.move_left  = v;
                BTN_DROP: b8.drop_piece = v;
                BTN_RST:  b8.restart    = v;
`ifdef CONNECT_UNDO_EN
                BTN_UNDO: b8.undo       = v;
`endif
                default: ;
            endcase
        end else begin
            case (b)
                BTN_R:    b4.move_right = v;
                BTN_L:    b4.move_left  = v;
                BTN_DROP: b4.drop_piece = v;
                BTN_RST:  b4.restart    = v;
`ifdef CONNECT_UNDO_EN
                BTN_UNDO: b4.undo       = v;
`endif
                default: ;
            endcase
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (obs(d, SEL_BUSY) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", obs(d, SEL_BUSY), 0);
    endtask

    task automatic press2(input int d, input int b1, input int b2);
        @(negedge clk);
        set_btn(d, b1, 1'b1);
        set_btn(d, b2, 1'b1);
        repeat (4) @(negedge clk);
        set_btn(d, b1, 1'b0);
        set_btn(d, b2, 1'b0);
        repeat (4) @(negedge clk);
        wait_idle(d);
    endtask

    task automatic move(input int d, input int b);
        int n;
        n = dim(d);
        mcol[d] = (b == BTN_R) ? (mcol[d] + 1) % n : (mcol[d] + n - 1) % n;
        push_exp("cur_col", d, SEL_COL, mcol[d]);
        press2(d, b, b);
        drain();
    endtask

    task automatic goto_col(input int d, input int t);
        while (mcol[d] != t) move(d, BTN_R);
    endtask

    task automatic drop(input int d, input bit legal, input int ew, input int ed);
        int c, r;
        c = mcol[d];
        r = mh[d][c];
        if (legal) begin
            mcell[d][r][c] = mply[d];
            mh[d][c]++;
            push_exp("drop_cell", d, SEL_CELL, mply[d], r, c);
            if (ew == 0 && ed == 0) mply[d] = 3 - mply[d];
        end else if (r < dim(d)) begin
            push_exp("ignored_cell", d, SEL_CELL, 0, r, c);
        end
        push_exp("winner", d, SEL_WIN, ew);
        push_exp("draw", d, SEL_DRAW, ed);
        push_exp("cur_player", d, SEL_PLY, mply[d]);
        push_exp("busy_after", d, SEL_BUSY, 0);
        press2(d, BTN_DROP, BTN_DROP);
        drain();
    endtask

    task automatic model_clear(input int d);
        for (int c = 0; c < 16; c++) begin
            mh[d][c] = 0;
            for (int r = 0; r < 16; r++) mcell[d][r][c] = 0;
        end
        mcol[d] = 0;
        mply[d] = 1;
    endtask

    task automatic push_idle_state(input int d);
        push_exp("cur_col", d, SEL_COL, 0);
        push_exp("cur_player", d, SEL_PLY, 1);
        push_exp("winner", d, SEL_WIN, 0);
        push_exp("draw", d, SEL_DRAW, 0);
        push_exp("busy", d, SEL_BUSY, 0);
        for (int r = 0; r < dim(d); r++)
            for (int c = 0; c < dim(d); c++)
                push_exp("clear_cell", d, SEL_CELL, mcell[d][r][c], r, c);
    endtask

    task automatic restart_game(input int d);
        model_clear(d);
        push_idle_state(d);
        press2(d, BTN_RST, BTN_RST);
        drain();
    endtask

    initial begin
        int cyc;
        int diag_cols[8] = '{0, 1, 3, 2, 3, 2, 0, 3};
        int draw_cols[16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};

        b8.move_right = 0; b8.move_left = 0; b8.drop_piece = 0; b8.restart = 0;
        b8.rd_row = '0; b8.rd_col = '0;
        b4.move_right = 0; b4.move_left = 0; b4.drop_piece = 0; b4.restart = 0;
        b4.rd_row = '0; b4.rd_col = '0;
`ifdef CONNECT_UNDO_EN
        b8.undo = 0;
        b4.undo = 0;
`endif
        model_clear(0);
        model_clear(1);

        // Reset values, clear sweep length, empty boards
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            push_exp("rst_busy", d, SEL_BUSY, 1);
            push_exp("rst_col", d, SEL_COL, 0);
            push_exp("rst_player", d, SEL_PLY, 1);
            push_exp("rst_winner", d, SEL_WIN, 0);
            push_exp("rst_draw", d, SEL_DRAW, 0);
        end
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (b8.busy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("clear_cycles", cyc, 8);
        wait_idle(1);
        push_idle_state(0);
        push_idle_state(1);
        drain();

        // Cursor wrap and left/right cancel
        move(0, BTN_L);
        push_exp("lr_cancel", 0, SEL_COL, mcol[0]);
        press2(0, BTN_L, BTN_R);
        drain();
        move(0, BTN_R);

        // Horizontal win for P1 with P2 stacking col 7
        goto_col(0, 0); drop(0, 1, 0, 0);
        goto_col(0, 7); drop(0, 1, 0, 0);
        goto_col(0, 1); drop(0, 1, 0, 0);
        goto_col(0, 7); drop(0, 1, 0, 0);
        goto_col(0, 2); drop(0, 1, 0, 0);
        goto_col(0, 7); drop(0, 1, 0, 0);
        goto_col(0, 3); drop(0, 1, 1, 0);

        // Terminal state ignores moves and drops
        push_exp("win_move_ignored", 0, SEL_COL, 3);
        press2(0, BTN_R, BTN_R);
        drain();
        drop(0, 0, 1, 0);
        restart_game(0);

        // Fill column 2, then the extra drop is ignored
        goto_col(0, 2);
        for (int i = 0; i < 8; i++) drop(0, 1, 0, 0);
        drop(0, 0, 0, 0);
        restart_game(0);

`ifdef CONNECT_UNDO_EN
        goto_col(0, 5);
        drop(0, 1, 0, 0);
        push_exp("undo_avail_set", 0, SEL_UNDO, 1);
        drain();
        mcell[0][0][5] = 0;
        mh[0][5] = 0;
        mply[0] = 1;
        for (int k = 0; k < 2; k++) begin
            push_exp("undo_cell", 0, SEL_CELL, 0, 0, 5);
            push_exp("undo_player", 0, SEL_PLY, 1);
            push_exp("undo_avail_clr", 0, SEL_UNDO, 0);
            press2(0, BTN_UNDO, BTN_UNDO);
            drain();
        end
        restart_game(0);
`endif

        // 4x4 connect-three: P2 diagonal (0,1)-(1,2)-(2,3)
        for (int i = 0; i < 8; i++) begin
            goto_col(1, diag_cols[i]);
            drop(1, 1, (i == 7) ? 2 : 0, 0);
        end
        restart_game(1);

        // 4x4 full board without any line of three
        for (int i = 0; i < 16; i++) begin
            goto_col(1, draw_cols[i]);
            drop(1, 1, 0, (i == 15) ? 1 : 0);
        end
        drop(1, 0, 0, 1);
        restart_game(1);

        // Reset asserted mid-CHECK on the 8x8 board
        goto_col(0, 3);
        @(negedge clk);
        b8.drop_piece = 1'b1;
        repeat (5) @(negedge clk);
        push_exp("mid_check_busy", 0, SEL_BUSY, 1);
        drain();
        rst_n = 1'b0;
        b8.drop_piece = 1'b0;
        push_exp("midrst_col", 0, SEL_COL, 0);
        push_exp("midrst_player", 0, SEL_PLY, 1);
        push_exp("midrst_winner", 0, SEL_WIN, 0);
        push_exp("midrst_busy", 0, SEL_BUSY, 1);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wait_idle(0);
        wait_idle(1);
        model_clear(0);
        model_clear(1);
        push_idle_state(0);
        push_idle_state(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
